// File: rtl/edge_lister_pkg.sv
// Shared defaults and FSM state encodings for the edge lister and the
// later edge-removal stage that reuses the lower-triangle index counter.
package edge_lister_pkg;

  localparam int MAX_NODES_DEF  = 16;
  localparam int NODE_WIDTH_DEF = 4;
  localparam int WGT_WIDTH_DEF  = 4;
  localparam int CNT_WIDTH_DEF  = 2 * NODE_WIDTH_DEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_EMIT = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

endpackage

// File: rtl/edge_lister_if.sv
// Valid/ready edge stream carrying (src, dst, weight) from the lister to the
// betweenness/edge-removal stages.
interface edge_lister_if #(
  parameter int NODE_WIDTH = edge_lister_pkg::NODE_WIDTH_DEF,
  parameter int WGT_WIDTH  = edge_lister_pkg::WGT_WIDTH_DEF
);

  logic                  edge_valid;
  logic                  edge_ready;
  logic [NODE_WIDTH-1:0] edge_src;
  logic [NODE_WIDTH-1:0] edge_dst;
  logic [WGT_WIDTH-1:0]  edge_wgt;

  modport master (
    output edge_valid,
    output edge_src,
    output edge_dst,
    output edge_wgt,
    input  edge_ready
  );

  modport slave (
    input  edge_valid,
    input  edge_src,
    input  edge_dst,
    input  edge_wgt,
    output edge_ready
  );

endinterface

// File: rtl/edge_lister_scan_idx.sv
// edge_scan_idx: walks (i,j) over the strictly-lower triangle, j<i<num_nodes,
// and flags the final cell so the caller can finish without an extra cycle.
module edge_scan_idx
  import edge_lister_pkg::*;
#(
  parameter int NODE_WIDTH = NODE_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init,
  input  logic                  adv,
  input  logic [NODE_WIDTH:0]   num_nodes,
  output logic [NODE_WIDTH-1:0] row,
  output logic [NODE_WIDTH-1:0] col,
  output logic                  last
);

  localparam logic [NODE_WIDTH-1:0] ONE_N  = NODE_WIDTH'(1);
  localparam logic [NODE_WIDTH-1:0] ZERO_N = {NODE_WIDTH{1'b0}};
  localparam logic [NODE_WIDTH:0]   ONE_W  = (NODE_WIDTH + 1)'(1);

  logic [NODE_WIDTH-1:0] row_r;
  logic [NODE_WIDTH-1:0] col_r;
  logic                  row_end_s;

  assign row_end_s = (col_r + ONE_N) == row_r;
  assign last      = row_end_s && ({1'b0, row_r} == (num_nodes - ONE_W));
  assign row       = row_r;
  assign col       = col_r;

  // Index register: restart at (1,0), otherwise step j then i; wraps after the last cell.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_r <= ONE_N;
      col_r <= ZERO_N;
    end else if (init) begin
      row_r <= ONE_N;
      col_r <= ZERO_N;
    end else if (adv) begin
      if (row_end_s) begin
        col_r <= ZERO_N;
        row_r <= last ? ONE_N : (row_r + ONE_N);
      end else begin
        col_r <= col_r + ONE_N;
      end
    end
  end

endmodule

// File: rtl/edge_lister.sv
// edge_lister: snapshots an adjacency matrix on start and streams every
// lower-triangle edge. Define EDGE_LISTER_SYMCHECK_EN to add the sticky asym_err check.
module edge_lister
  import edge_lister_pkg::*;
#(
  parameter int MAX_NODES  = MAX_NODES_DEF,
  parameter int NODE_WIDTH = $clog2(MAX_NODES),
  parameter int WGT_WIDTH  = WGT_WIDTH_DEF,
  parameter int CNT_WIDTH  = 2 * NODE_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [0:MAX_NODES*MAX_NODES-1] graph_in,
  input  logic [NODE_WIDTH:0]            num_nodes,
  edge_lister_if.master                  edge_if,
  output logic                           busy,
  output logic                           done,
  output logic [CNT_WIDTH-1:0]           edge_count,
  output logic                           asym_err
);

  localparam logic [NODE_WIDTH:0]   MAX_NODES_V = (NODE_WIDTH + 1)'(MAX_NODES);
  localparam logic [NODE_WIDTH:0]   TWO_V       = (NODE_WIDTH + 1)'(2);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE     = CNT_WIDTH'(1);
  localparam logic [NODE_WIDTH-1:0] ZERO_N      = {NODE_WIDTH{1'b0}};

  state_t                         state_r;
  state_t                         next_state_s;
  logic [0:MAX_NODES*MAX_NODES-1] snap_r;
  logic [NODE_WIDTH:0]            nn_r;
  logic [NODE_WIDTH:0]            nn_clamp_s;
  logic [NODE_WIDTH-1:0]          row_s;
  logic [NODE_WIDTH-1:0]          col_s;
  logic                           last_s;
  logic                           cell_bit_s;
  logic                           accept_s;
  logic                           idx_init_s;
  logic                           idx_adv_s;
  logic                           load_edge_s;
  logic                           handshake_s;
  logic                           edge_valid_r;
  logic [NODE_WIDTH-1:0]          edge_src_r;
  logic [NODE_WIDTH-1:0]          edge_dst_r;
  logic                           busy_r;
  logic                           done_r;
  logic [CNT_WIDTH-1:0]           edge_count_r;

  assign nn_clamp_s = (num_nodes > MAX_NODES_V) ? MAX_NODES_V : num_nodes;
  // Power-of-two MAX_NODES makes i*MAX_NODES+j a plain concatenation.
  assign cell_bit_s = snap_r[{row_s, col_s}];

  edge_scan_idx #(
    .NODE_WIDTH (NODE_WIDTH)
  ) u_scan_idx (
    .clk       (clk),
    .rst       (rst),
    .init      (idx_init_s),
    .adv       (idx_adv_s),
    .num_nodes (nn_r),
    .row       (row_s),
    .col       (col_s),
    .last      (last_s)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    idx_init_s   = 1'b0;
    idx_adv_s    = 1'b0;
    load_edge_s  = 1'b0;
    handshake_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          accept_s   = 1'b1;
          idx_init_s = 1'b1;
          if (nn_clamp_s < TWO_V) begin
            next_state_s = ST_FIN;
          end else begin
            next_state_s = ST_SCAN;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (cell_bit_s) begin
          load_edge_s  = 1'b1;
          next_state_s = ST_EMIT;
        end else begin
          idx_adv_s    = 1'b1;
          next_state_s = last_s ? ST_FIN : ST_SCAN;
        end
      end
      ST_EMIT: begin
        if (edge_if.edge_ready) begin
          handshake_s  = 1'b1;
          idx_adv_s    = 1'b1;
          next_state_s = last_s ? ST_FIN : ST_SCAN;
        end else begin
          next_state_s = ST_EMIT;
        end
      end
      ST_FIN: begin
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Snapshot, edge output register, counters and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_r       <= {(MAX_NODES * MAX_NODES){1'b0}};
      nn_r         <= {(NODE_WIDTH + 1){1'b0}};
      edge_valid_r <= 1'b0;
      edge_src_r   <= ZERO_N;
      edge_dst_r   <= ZERO_N;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      edge_count_r <= {CNT_WIDTH{1'b0}};
    end else begin
      if (accept_s) begin
        snap_r <= graph_in;
        nn_r   <= nn_clamp_s;
      end
      if (load_edge_s) begin
        edge_valid_r <= 1'b1;
        edge_src_r   <= row_s;
        edge_dst_r   <= col_s;
      end else if (handshake_s) begin
        edge_valid_r <= 1'b0;
      end
      if (accept_s) begin
        edge_count_r <= {CNT_WIDTH{1'b0}};
      end else if (handshake_s) begin
        edge_count_r <= edge_count_r + CNT_ONE;
      end
      busy_r <= (next_state_s == ST_SCAN) || (next_state_s == ST_EMIT);
      done_r <= (next_state_s == ST_FIN);
    end
  end

`ifdef EDGE_LISTER_SYMCHECK_EN
  logic mirror_bit_s;
  logic asym_err_r;

  assign mirror_bit_s = snap_r[{col_s, row_s}];

  // Sticky mismatch between (i,j) and (j,i); cleared only by an accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asym_err_r <= 1'b0;
    end else if (accept_s) begin
      asym_err_r <= 1'b0;
    end else if ((state_r == ST_SCAN) && (cell_bit_s != mirror_bit_s)) begin
      asym_err_r <= 1'b1;
    end
  end

  assign asym_err = asym_err_r;
`else
  assign asym_err = 1'b0;
`endif

  assign edge_if.edge_valid = edge_valid_r;
  assign edge_if.edge_src   = edge_src_r;
  assign edge_if.edge_dst   = edge_dst_r;
  assign edge_if.edge_wgt   = {WGT_WIDTH{1'b0}};
  assign busy               = busy_r;
  assign done               = done_r;
  assign edge_count         = edge_count_r;

endmodule

// File: tb/tb_edge_lister.sv
// Directed bench for edge_lister: expected edges are queued at start and
// popped on each valid/ready handshake.
module tb_edge_lister;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [0:255] graph_in;
  logic [4:0]   num_nodes;
  logic         busy;
  logic         done;
  logic         asym_err;
  logic [7:0]   edge_count;

  int           n_assert = 0;
  int           n_fail   = 0;
  logic [7:0]   exp_q[$];
  logic [0:255] g_path;
  logic [0:255] g_work;

`ifdef EDGE_LISTER_SYMCHECK_EN
  localparam logic ASYM_EXP = 1'b1;
`else
  localparam logic ASYM_EXP = 1'b0;
`endif

  always #5 clk = ~clk;

  edge_lister_if #(.NODE_WIDTH(4), .WGT_WIDTH(4)) eif ();

  edge_lister #(
    .MAX_NODES  (16),
    .NODE_WIDTH (4),
    .WGT_WIDTH  (4),
    .CNT_WIDTH  (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .graph_in   (graph_in),
    .num_nodes  (num_nodes),
    .edge_if    (eif),
    .busy       (busy),
    .done       (done),
    .edge_count (edge_count),
    .asym_err   (asym_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [0:255] sym(input logic [0:255] g, input int a, input int b);
    logic [0:255] r;
    r = g;
    r[a*16+b] = 1'b1;
    r[b*16+a] = 1'b1;
    return r;
  endfunction

  task automatic push_exp(input int s, input int d);
    exp_q.push_back({4'(s), 4'(d)});
  endtask

  task automatic do_start(input logic [0:255] g, input logic [4:0] n);
    @(negedge clk);
    graph_in  = g;
    num_nodes = n;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  // Called at the first negedge after the start edge (cycle 1).
  task automatic run_scan(input string tag, input int stall_edge, input int stall_len,
                          input int exp_done_cyc, input int poke_cyc,
                          input logic [7:0] exp_cnt, input logic exp_asym);
    int cyc       = 0;
    int edge_no   = 0;
    int stall_cnt = 0;
    bit got_done  = 1'b0;
    while (!got_done && cyc < 400) begin
      cyc++;
      if (cyc == poke_cyc) begin
        start     = 1'b1;
        num_nodes = 5'd2;
        graph_in  = '0;
      end else begin
        start = 1'b0;
      end
      if (eif.edge_valid) begin
        if (exp_q.size() == 0) begin
          check({tag, "_extra_edge"}, 32'(exp_q.size()), 32'd1);
          eif.edge_ready = 1'b1;
          edge_no++;
        end else if (edge_no == stall_edge && stall_cnt < stall_len) begin
          eif.edge_ready = 1'b0;
          stall_cnt++;
          check({tag, "_stall_hold"}, {eif.edge_wgt, eif.edge_src, eif.edge_dst}, {4'h0, exp_q[0]});
        end else begin
          eif.edge_ready = 1'b1;
          check({tag, "_edge"}, {eif.edge_wgt, eif.edge_src, eif.edge_dst}, {4'h0, exp_q.pop_front()});
          edge_no++;
        end
      end else begin
        eif.edge_ready = 1'($urandom_range(0, 1));
      end
      if (done) begin
        got_done = 1'b1;
        check({tag, "_done_cycle"}, 32'(cyc), 32'(exp_done_cyc));
        check({tag, "_count"}, edge_count, exp_cnt);
        check({tag, "_busy_at_done"}, busy, 1'b0);
        check({tag, "_asym"}, asym_err, exp_asym);
        check({tag, "_leftover"}, 32'(exp_q.size()), 32'd0);
      end
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_done_seen"}, got_done, 1'b1);
    check({tag, "_done_pulse"}, {done, eif.edge_valid}, 2'b00);
    exp_q.delete();
  endtask

  initial begin
    rst            = 1'b1;
    start          = 1'b0;
    graph_in       = '0;
    num_nodes      = 5'd0;
    eif.edge_ready = 1'b0;
    g_path         = '0;
    g_path         = sym(g_path, 1, 0);
    g_path         = sym(g_path, 2, 1);
    g_path         = sym(g_path, 3, 2);

    repeat (2) @(negedge clk);
    check("reset_flags", {eif.edge_valid, busy, done, asym_err}, 4'b0000);
    check("reset_edge", {eif.edge_wgt, eif.edge_src, eif.edge_dst}, 12'h000);
    check("reset_count", edge_count, 8'd0);
    rst = 1'b0;

    // Reset while an edge is held in EMIT.
    do_start(g_path, 5'd4);
    begin
      int w = 0;
      while (!eif.edge_valid && w < 10) begin
        @(negedge clk);
        w++;
      end
    end
    check("rst_emit_reached", eif.edge_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("rst_emit_flags", {eif.edge_valid, busy, done}, 3'b000);
    check("rst_emit_edge", {eif.edge_src, eif.edge_dst}, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    push_exp(1, 0); push_exp(2, 1); push_exp(3, 2);
    do_start(g_path, 5'd4);
    run_scan("path", -1, 0, 10, -1, 8'd3, 1'b0);

    push_exp(1, 0); push_exp(2, 1); push_exp(3, 2);
    do_start(g_path, 5'd4);
    run_scan("stall", 1, 5, 15, -1, 8'd3, 1'b0);

    g_work = '0;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        if (i != j) g_work[i*16+j] = 1'b1;
      end
    end
    for (int i = 1; i < 16; i++) begin
      for (int j = 0; j < i; j++) push_exp(i, j);
    end
    do_start(g_work, 5'd16);
    graph_in = '0;
    run_scan("clique", -1, 0, 241, 50, 8'd120, 1'b0);

    g_work = '0;
    g_work = sym(g_work, 2, 0);
    g_work[2*16+2] = 1'b1;
    g_work = sym(g_work, 5, 1);
    g_work = sym(g_work, 4, 2);
    push_exp(2, 0);
    do_start(g_work, 5'd3);
    run_scan("range3", -1, 0, 5, -1, 8'd1, 1'b0);

    do_start(g_work, 5'd1);
    run_scan("nn1", -1, 0, 1, -1, 8'd0, 1'b0);

    do_start(g_work, 5'd0);
    run_scan("nn0", -1, 0, 1, -1, 8'd0, 1'b0);

    g_work = '0;
    g_work = sym(g_work, 15, 14);
    push_exp(15, 14);
    do_start(g_work, 5'd20);
    run_scan("clamp", -1, 0, 122, -1, 8'd1, 1'b0);
    repeat (3) @(negedge clk);
    check("count_hold", edge_count, 8'd1);

    g_work = '0;
    g_work[2*16+0] = 1'b1;
    push_exp(2, 0);
    do_start(g_work, 5'd4);
    run_scan("asym", -1, 0, 8, -1, 8'd1, ASYM_EXP);
    repeat (3) @(negedge clk);
    check("asym_sticky", asym_err, ASYM_EXP);

    push_exp(1, 0); push_exp(2, 1); push_exp(3, 2);
    do_start(g_path, 5'd4);
    run_scan("asym_clear", -1, 0, 10, -1, 8'd3, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
